sample_buffer_ctrl: RTL

SAMPLE_BUFFER_CTRL -- requirements
Module: sample_buffer_ctrl

---
 rtl/sample_buffer_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/sample_buffer_ctrl.sv
// Frame capture buffer: fills an external RAM with DEPTH incoming samples,
// then streams them out over a valid/ready interface.
module sample_buffer_ctrl #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     di_valid,
  input  logic [DATA_WIDTH-1:0]    di,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_di,
  input  logic [DATA_WIDTH-1:0]    ram_do,
  output logic                     do_valid,
  input  logic                     do_ready,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     last,
  output logic                     busy,
  output logic                     overflow
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [ADDRESS_WIDTH-1:0] raddr;
  logic                     rd_done;
  logic                     advance;
  logic                     wr_issue;
  logic                     rd_issue;

  // RAM strobes are combinational so a write lands in the same cycle as di_valid.
  always_comb begin
    advance  = !do_valid || do_ready;
    wr_issue = !rst && (state == FILL) && di_valid;
    rd_issue = !rst && (state == DRAIN) && !rd_done && advance;
    ram_en   = wr_issue || rd_issue;
    ram_we   = wr_issue;
    ram_addr = '0;
    if (wr_issue)
      ram_addr = waddr;
    else if (rd_issue)
      ram_addr = raddr;
  end

  assign ram_di = di;
  assign data_o = ram_do;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      waddr    <= '0;
      raddr    <= '0;
      rd_done  <= 1'b0;
      do_valid <= 1'b0;
      last     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= di_valid && (state != FILL);
      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            waddr <= '0;
          end
        end
        FILL: begin
          if (di_valid) begin
            if (waddr == LAST_ADDR) begin
              state   <= DRAIN;
              raddr   <= '0;
              rd_done <= 1'b0;
            end else begin
              waddr <= waddr + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Address saturates at the final sample; rd_done marks reads exhausted.
          if (rd_issue) begin
            do_valid <= 1'b1;
            last     <= (raddr == LAST_ADDR);
            if (raddr == LAST_ADDR)
              rd_done <= 1'b1;
            else
              raddr <= raddr + 1'b1;
          end else if (do_ready) begin
            do_valid <= 1'b0;
            last     <= 1'b0;
          end
          if (do_valid && do_ready && last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
